// File: rtl/evm_ballot_ctrl.sv
// Ballot controller: synchronised buttons/mode, READY/VOTED/TIMEOUT/LOCKED session FSM with a
// tick-based voter timeout, saturating tallies and registered readout with leader/tie detection.
module evm_ballot_ctrl #(
   parameter int  N_CAND       = 4,
   parameter int  CNT_W        = 8,
   parameter int  TICK_DIV     = 33554432,
   parameter int  VOTE_TIMEOUT = 12,
   localparam int SEL_W        = (N_CAND > 2) ? $clog2(N_CAND) : 1,
   localparam int TOT_W        = CNT_W + SEL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CAND-1:0] btn,
   input  logic [1:0]        mode,
   output logic [N_CAND-1:0] lamp,
   output logic [2:0]        rgb,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [CNT_W-1:0]  rd_tally,
   output logic [TOT_W-1:0]  total,
   output logic [CNT_W-1:0]  spoilt,
   output logic [SEL_W-1:0]  leader,
   output logic              tie,
   output logic              results_valid,
   output logic              tick
);
   localparam int               DIV_W    = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
   localparam logic [7:0]       TMO_LAST = 8'(VOTE_TIMEOUT - 1);
   localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_CAND);

   localparam logic [1:0] M_VOTE  = 2'b00;
   localparam logic [1:0] M_LOCK  = 2'b01;
   localparam logic [1:0] M_ARM   = 2'b10;
   localparam logic [1:0] M_CLEAR = 2'b11;

   localparam logic [2:0] RGB_READY = 3'b010;
   localparam logic [2:0] RGB_BUSY  = 3'b100;
   localparam logic [2:0] RGB_TMO   = 3'b001;

   typedef enum logic [1:0] {S_READY, S_VOTED, S_TIMEOUT, S_LOCKED} state_t;

   logic [1:0]        rst_sync_q;
   logic              rst_int_n;
   logic [N_CAND-1:0] btn_s1_q, btn_s2_q, btn_prev_q;
   logic [1:0]        mode_s1_q, mode_s2_q;
   logic [DIV_W-1:0]  div_q;
   logic              tick_q;

   state_t            state_q;
   logic [CNT_W-1:0]  tally_q [N_CAND];
   logic [TOT_W-1:0]  total_q;
   logic [CNT_W-1:0]  spoilt_q;
   logic [7:0]        timer_q;
   logic [N_CAND-1:0] lamp_q;
   logic [2:0]        rgb_q;
   logic              rv_q;

   logic [CNT_W-1:0]  rd_tally_q;
   logic [SEL_W-1:0]  leader_q, leader_d;
   logic              tie_q, tie_d;
   logic [CNT_W-1:0]  max_d;

   logic [N_CAND-1:0] edges;
   logic [SEL_W:0]    n_edges_d;
   logic [SEL_W-1:0]  edge_idx_d;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_prev_q <= '0;
         mode_s1_q  <= '0;
         mode_s2_q  <= '0;
      end else begin
         btn_s1_q   <= btn;
         btn_s2_q   <= btn_s1_q;
         btn_prev_q <= btn_s2_q;
         mode_s1_q  <= mode;
         mode_s2_q  <= mode_s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (div_q == DIV_MAX);
         div_q  <= (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      end
   end

   assign edges = btn_s2_q & ~btn_prev_q;

   always_comb begin
      n_edges_d  = '0;
      edge_idx_d = '0;
      for (int i = N_CAND - 1; i >= 0; i--) begin
         if (edges[i]) begin
            n_edges_d  = n_edges_d + (SEL_W + 1)'(1);
            edge_idx_d = SEL_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q  <= S_READY;
         total_q  <= '0;
         spoilt_q <= '0;
         timer_q  <= '0;
         lamp_q   <= '0;
         rgb_q    <= RGB_READY;
         rv_q     <= 1'b0;
         for (int i = 0; i < N_CAND; i++) tally_q[i] <= '0;
      end else if (mode_s2_q == M_CLEAR) begin
         state_q  <= S_READY;
         total_q  <= '0;
         spoilt_q <= '0;
         timer_q  <= '0;
         lamp_q   <= '0;
         rgb_q    <= RGB_READY;
         rv_q     <= 1'b0;
         for (int i = 0; i < N_CAND; i++) tally_q[i] <= '0;
      end else if (mode_s2_q == M_LOCK) begin
         state_q <= S_LOCKED;
         rgb_q   <= RGB_BUSY;
         rv_q    <= 1'b1;
      end else begin
         case (state_q)
            S_READY: begin
               if (mode_s2_q == M_VOTE) begin
                  if (n_edges_d == (SEL_W + 1)'(1)) begin
                     if (tally_q[edge_idx_d] != '1) tally_q[edge_idx_d] <= tally_q[edge_idx_d] + 1'b1;
                     if (total_q != '1) total_q <= total_q + 1'b1;
                     lamp_q  <= edges;
                     state_q <= S_VOTED;
                     rgb_q   <= RGB_BUSY;
                  end else if (n_edges_d != '0) begin
                     if (spoilt_q != '1) spoilt_q <= spoilt_q + 1'b1;
                     lamp_q  <= '0;
                     state_q <= S_VOTED;
                     rgb_q   <= RGB_BUSY;
                  end else if (tick_q) begin
                     // A vote in the same cycle as the last tick is handled above and wins.
                     timer_q <= timer_q + 1'b1;
                     if (timer_q == TMO_LAST) begin
                        state_q <= S_TIMEOUT;
                        rgb_q   <= RGB_TMO;
                     end
                  end
               end
            end
            S_VOTED, S_TIMEOUT, S_LOCKED: begin
               if (mode_s2_q == M_ARM) begin
                  state_q <= S_READY;
                  rgb_q   <= RGB_READY;
                  lamp_q  <= '0;
                  timer_q <= '0;
                  rv_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= S_READY;
               rgb_q   <= RGB_READY;
            end
         endcase
      end
   end

   always_comb begin
      max_d    = '0;
      leader_d = '0;
      tie_d    = 1'b0;
      for (int i = 0; i < N_CAND; i++) begin
         if (tally_q[i] > max_d) begin
            max_d    = tally_q[i];
            leader_d = SEL_W'(i);
            tie_d    = 1'b0;
         end else if ((tally_q[i] == max_d) && (max_d != '0)) begin
            tie_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         rd_tally_q <= '0;
         leader_q   <= '0;
         tie_q      <= 1'b0;
      end else begin
         rd_tally_q <= ({1'b0, rd_sel} < N_LIM) ? tally_q[rd_sel] : '0;
         leader_q   <= leader_d;
         tie_q      <= tie_d;
      end
   end

   assign lamp          = lamp_q;
   assign rgb           = rgb_q;
   assign rd_tally      = rd_tally_q;
   assign total         = total_q;
   assign spoilt        = spoilt_q;
   assign leader        = leader_q;
   assign tie           = tie_q;
   assign results_valid = rv_q;
   assign tick          = tick_q;
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Scoreboard bench for evm_ballot_ctrl: directed session scenarios followed by random operations,
// checked against a ballot-level model of tallies, counters and session state.
module tb_evm_ballot_ctrl;
   localparam int N  = 4;
   localparam int CW = 2;
   localparam int TD = 4;
   localparam int VT = 3;
   localparam int SW = 2;
   localparam int TW = CW + SW;

   localparam logic [1:0] M_VOTE = 2'b00, M_LOCK = 2'b01, M_ARM = 2'b10, M_CLEAR = 2'b11;
   localparam int ST_READY = 0, ST_VOTED = 1, ST_TMO = 2, ST_LOCKED = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  btn;
   logic [1:0]    mode;
   logic [SW-1:0] rd_sel;
   logic [N-1:0]  lamp;
   logic [2:0]    rgb;
   logic [CW-1:0] rd_tally;
   logic [TW-1:0] total;
   logic [CW-1:0] spoilt;
   logic [SW-1:0] leader;
   logic          tie, results_valid, tick;

   evm_ballot_ctrl #(.N_CAND(N), .CNT_W(CW), .TICK_DIV(TD), .VOTE_TIMEOUT(VT)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .mode(mode), .lamp(lamp), .rgb(rgb),
      .rd_sel(rd_sel), .rd_tally(rd_tally), .total(total), .spoilt(spoilt),
      .leader(leader), .tie(tie), .results_valid(results_valid), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    rgb, lamp, total, spoilt, rd_tally, leader, tie, rv;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_errors = 0;

   int m_tally[N];
   int m_total, m_spoilt, m_lamp, m_state;

   task automatic cmp(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   function automatic int sat(input int v, input int w);
      return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
   endfunction

   function automatic int rgb_of(input int st);
      if (st == ST_READY) return 2;
      if (st == ST_TMO)   return 1;
      return 4;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_tally[i] = 0;
      m_total  = 0;
      m_spoilt = 0;
      m_lamp   = 0;
      m_state  = ST_READY;
   endtask

   task automatic push_exp(input string nm);
      exp_t e;
      int top, cnt;
      top = 0;
      cnt = 0;
      for (int i = 0; i < N; i++) if (m_tally[i] > top) top = m_tally[i];
      e.leader = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (m_tally[i] == top) begin
            e.leader = i;
            cnt++;
         end
      end
      e.name     = nm;
      e.tie      = (top > 0 && cnt > 1) ? 1 : 0;
      e.rgb      = rgb_of(m_state);
      e.lamp     = m_lamp;
      e.total    = m_total;
      e.spoilt   = m_spoilt;
      e.rd_tally = m_tally[rd_sel];
      e.rv       = (m_state == ST_LOCKED) ? 1 : 0;
      exp_q.push_back(e);
      step(1);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         cmp({cur.name, ".rgb"},           rgb,           cur.rgb);
         cmp({cur.name, ".lamp"},          lamp,          cur.lamp);
         cmp({cur.name, ".total"},         total,         cur.total);
         cmp({cur.name, ".spoilt"},        spoilt,        cur.spoilt);
         cmp({cur.name, ".rd_tally"},      rd_tally,      cur.rd_tally);
         cmp({cur.name, ".leader"},        leader,        cur.leader);
         cmp({cur.name, ".tie"},           tie,           cur.tie);
         cmp({cur.name, ".results_valid"}, results_valid, cur.rv);
      end
   end

   int cyc_n = 0;
   int last_tick = -1;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_tick = -1;
         cmp("tick_in_reset", tick, 0);
      end else if (tick) begin
         if (last_tick >= 0) cmp("tick_period", cyc_n - last_tick, TD);
         last_tick = cyc_n;
      end
   end

   task automatic go_arm(input string nm);
      mode = M_ARM;
      btn  = '0;
      step(5);
      if (m_state != ST_READY) begin
         m_state = ST_READY;
         m_lamp  = 0;
      end
      push_exp(nm);
   endtask

   task automatic do_vote(input int c, input bit extra, input bit arm);
      rd_sel = SW'($urandom_range(0, N - 1));
      mode   = M_VOTE;
      btn    = N'(1 << c);
      step(6);
      m_tally[c] = sat(m_tally[c] + 1, CW);
      m_total    = sat(m_total + 1, TW);
      m_lamp     = 1 << c;
      m_state    = ST_VOTED;
      push_exp("vote");
      if (extra) begin
         btn = btn | N'(1 << ((c + 1 + int'($urandom_range(0, N - 2))) % N));
         step(5);
         push_exp("voted_ignores_btn");
      end
      if (arm) go_arm("arm_after_vote");
   endtask

   task automatic do_spoil(input logic [N-1:0] mask);
      rd_sel = SW'($urandom_range(0, N - 1));
      mode   = M_VOTE;
      btn    = mask;
      step(6);
      m_spoilt = sat(m_spoilt + 1, CW);
      m_lamp   = 0;
      m_state  = ST_VOTED;
      push_exp("spoil");
      go_arm("arm_after_spoil");
   endtask

   task automatic do_timeout();
      bit seen;
      seen   = 1'b0;
      rd_sel = SW'($urandom_range(0, N - 1));
      mode   = M_VOTE;
      btn    = '0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1);
         if (rgb == 3'b001) seen = 1'b1;
      end
      m_state = ST_TMO;
      step(2);
      push_exp("timeout");
      go_arm("arm_after_timeout");
   endtask

   task automatic do_lock();
      rd_sel = SW'($urandom_range(0, N - 1));
      mode   = M_LOCK;
      step(5);
      m_state = ST_LOCKED;
      push_exp("lock");
      for (int i = 0; i < N; i++) begin
         rd_sel = SW'(i);
         step(1);
         push_exp("locked_readout");
      end
      mode = M_VOTE;
      step(4);
      push_exp("locked_vote_stays");
      go_arm("arm_after_lock");
   endtask

   task automatic do_clear();
      mode = M_CLEAR;
      btn  = '0;
      step(5);
      model_clear();
      push_exp("clear");
      step(3);
      push_exp("clear_held");
      go_arm("arm_after_clear");
   endtask

   initial begin
      rst_n  = 1'b1;
      btn    = '0;
      mode   = M_ARM;
      rd_sel = '0;
      model_clear();
      #1 rst_n = 1'b0;
      step(3);
      push_exp("reset");
      rst_n = 1'b1;
      step(5);
      push_exp("after_reset");

      do_vote(2, 1'b1, 1'b1);

      // Candidate 0 stays pressed across ARM, so re-entering VOTE must not count it again.
      do_vote(0, 1'b0, 1'b0);
      mode = M_ARM;
      step(5);
      m_state = ST_READY;
      m_lamp  = 0;
      push_exp("arm_btn_held");
      mode = M_VOTE;
      step(4);
      push_exp("held_no_vote");
      mode = M_ARM;
      btn  = '0;
      step(3);

      do_timeout();
      do_spoil(4'b1010);

      do_clear();
      do_vote(2, 1'b0, 1'b1);
      do_vote(2, 1'b0, 1'b1);
      do_vote(1, 1'b0, 1'b1);
      do_vote(1, 1'b0, 1'b0);
      do_lock();

      do_clear();
      repeat (4) do_vote(0, 1'b0, 1'b1);
      do_clear();

      do_vote(1, 1'b0, 1'b0);
      rst_n = 1'b0;
      btn   = '0;
      mode  = M_ARM;
      step(1);
      model_clear();
      push_exp("reset_mid_voted");
      step(2);
      rst_n = 1'b1;
      step(5);
      push_exp("after_reset2");

      for (int k = 0; k < 30; k++) begin
         int r;
         logic [N-1:0] mk;
         r = int'($urandom_range(0, 9));
         if (r < 4) begin
            do_vote(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 1'b1);
         end else if (r < 6) begin
            do mk = N'($urandom_range(0, (1 << N) - 1)); while ($countones(mk) < 2);
            do_spoil(mk);
         end else if (r < 7) begin
            do_timeout();
         end else if (r < 9) begin
            do_lock();
         end else begin
            do_clear();
         end
      end

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
      $fatal(1, "time limit");
   end
endmodule

// File: doc/evm_ballot_ctrl.md
Name: evm_ballot_ctrl

Overview:
Parametrised ballot controller for the electronic voting machine. It supports N candidate buttons and saturating tally counters, and enforces a per-voter time window derived from an internal tick divider. It runs a session FSM: ready, voted, timeout, locked. It also provides registered result readout with leader and tie detection for the display/result stage.

Parameters:
N_CAND, 4, number of candidates/buttons (2..16)
CNT_W, 8, width of each tally counter (saturating)
TICK_DIV, 33554432, clk cycles per timing tick (>=2)
VOTE_TIMEOUT, 12, ticks allowed in READY before TIMEOUT (1..255)
localparam SEL_W = max(1, clog2(N_CAND)); TOT_W = CNT_W+SEL_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn  in  N_CAND  raw candidate buttons, active-high, asynchronous
mode  in  2  operator switch: 00 VOTE, 01 LOCK, 10 ARM (next voter), 11 CLEAR; asynchronous
lamp  out  N_CAND  one-hot lamp of the candidate just voted
rgb  out  3  status: 010 ready, 100 voted/locked, 001 timeout
rd_sel  in  SEL_W  tally readout index
rd_tally  out  CNT_W  tally of rd_sel, registered
total  out  TOT_W  count of accepted votes
spoilt  out  CNT_W  count of multi-press ballots (saturating)
leader  out  SEL_W  index of the highest tally
tie  out  1  top tally is shared and >0
results_valid  out  1  high only in LOCKED
tick  out  1  one-cycle tick pulse (debug/display strobe)

Behaviour:
- Reset (async assert, sync deassert internally): state READY. Tallies, total, spoilt, timer, lamp, rd_tally, leader, tie and tick are all 0. rgb=010. results_valid=0.
- btn and mode each pass through 2-flop synchronisers. Button rising edge = sync_now & ~sync_prev. Mode is decoded from the synchronised value only.
- Tick: counter 0..TICK_DIV-1. tick=1 for the single cycle where the count wraps. It free-runs in all states.
- Mode priority, evaluated every cycle:
  - CLEAR: zero tallies, total, spoilt, timer and lamp; go to READY. Held CLEAR keeps the block cleared.
  - LOCK: go to LOCKED from any state. Lamp is kept.
- READY (rgb 010), mode VOTE:
  - Exactly one button edge: tally[i]++ saturating at 2^CNT_W-1; total++ saturating; lamp=onehot(i); go to VOTED. Update is visible the next cycle.
  - Two or more edges in the same cycle: spoilt++; lamp=0; go to VOTED. No tally changes.
  - No edge and tick=1: timer++. When timer reaches VOTE_TIMEOUT, go to TIMEOUT.
  - A vote edge and the final tick in the same cycle: the vote wins.
- READY with mode ARM: stay in READY; the timer is held and edges are ignored.
- VOTED (100) and TIMEOUT (001): all button edges are ignored. mode ARM gives READY, lamp=0, timer=0.
- LOCKED (100): edges are ignored. ARM gives READY with tallies kept. CLEAR gives READY with everything cleared. VOTE stays in LOCKED.
- A button held across ARM produces no edge, so no vote is taken until it is released and pressed again.
- Readout:
  - rd_tally = tally[rd_sel], registered, 1-cycle latency. rd_sel >= N_CAND returns 0.
  - leader and tie are registered, recomputed each cycle from the current tallies, so they lag a tally update by 1 cycle.
  - leader is the lowest index holding the maximum. All-zero tallies give leader=0, tie=0.
- rst_n asserted mid-session aborts the session immediately; all state returns to the reset values.

Test Plan:
- N_CAND=4, TICK_DIV=4, VOTE_TIMEOUT=3. Reset; VOTE; pulse btn[2] -> tally2=1, total=1, lamp=0100, rgb=100. Further btn[1] presses -> no change.
- VOTED, then ARM, then VOTE; pulse btn[0] -> lamp=0001, rgb=100, tally0=1. Next, btn[0] held across ARM, no release -> no vote taken.
- In READY press no button for 3 ticks (12 clk) -> rgb=001, lamp=0000, tallies unchanged. ARM -> rgb=010, timer=0.
- btn[1] and btn[3] rise in the same cycle -> spoilt=1, total unchanged, lamp=0000, rgb=100.
- Votes 2,2,1,1 then LOCK -> results_valid=1, leader=1, tie=1. rd_sel=1 gives rd_tally=2 after 1 cycle. rd_sel beyond N_CAND-1 gives 0 (only reachable when N_CAND is not a power of 2).
- CNT_W=2: four votes for candidate 0 -> tally0 saturates at 3, total=4. Then CLEAR -> all counters 0. Also assert rst_n low mid-VOTED -> immediate READY, rgb=010, lamp=0.
